// File: rtl/branch_fetch_control.sv
// Fetch PC sequencer: redirects on predicted-taken branches, tracks one outstanding
// predicted branch, recovers on mispredict and strobes predictor training updates.
module branch_fetch_control #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                INSTR_BYTES = 4,
  parameter int                CNT_W       = 16
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStall,
  input  logic              iBranchDecoded,
  input  logic [ADDR_W-1:0] iBranchPC,
  input  logic [ADDR_W-1:0] iBranchTarget,
  input  logic              iPredictTake,
  input  logic              iResolveValid,
  input  logic              iResolveTaken,
  output logic [ADDR_W-1:0] oPC,
  output logic              oFlush,
  output logic              oBranchCmd,
  output logic              oBranchTaken,
  output logic              oBranchHold,
  output logic [CNT_W-1:0]  oMispredictCount
);

  typedef enum logic {IDLE, PENDING} state_t;

  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INSTR_BYTES);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               pred_q, pred_d;
  logic [ADDR_W-1:0]  tgt_q, tgt_d;
  logic [ADDR_W-1:0]  fall_q, fall_d;
  logic               flush_q, flush_d;
  logic               cmd_q, cmd_d;
  logic               taken_q, taken_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic resolve, mispredict, accept;

  always_comb begin
    resolve    = iResolveValid && (state_q == PENDING);
    mispredict = resolve && (iResolveTaken != pred_q);
    // a branch decoded alongside a mispredict is wrong-path: neither held nor accepted
    accept     = iBranchDecoded && !iStall && !mispredict &&
                 ((state_q == IDLE) || resolve);

    state_d = state_q;
    pc_d    = pc_q + STEP;
    pred_d  = pred_q;
    tgt_d   = tgt_q;
    fall_d  = fall_q;
    flush_d = mispredict;
    cmd_d   = resolve;
    taken_d = resolve && iResolveTaken;
    cnt_d   = cnt_q;

    if (mispredict) begin
      pc_d = iResolveTaken ? tgt_q : fall_q;
    end else if (iStall) begin
      pc_d = pc_q;
    end else if (accept && iPredictTake) begin
      pc_d = iBranchTarget;
    end

    if (mispredict) begin
      state_d = IDLE;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end else if (accept) begin
      state_d = PENDING;
      pred_d  = iPredictTake;
      tgt_d   = iBranchTarget;
      fall_d  = iBranchPC + STEP;
    end else if (resolve) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pred_q  <= 1'b0;
      tgt_q   <= '0;
      fall_q  <= '0;
      flush_q <= 1'b0;
      cmd_q   <= 1'b0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pred_q  <= pred_d;
      tgt_q   <= tgt_d;
      fall_q  <= fall_d;
      flush_q <= flush_d;
      cmd_q   <= cmd_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

  assign oBranchHold      = iBranchDecoded && (state_q == PENDING) && !iResolveValid;
  assign oPC              = pc_q;
  assign oFlush           = flush_q;
  assign oBranchCmd       = cmd_q;
  assign oBranchTaken     = taken_q;
  assign oMispredictCount = cnt_q;

endmodule

// File: doc/branch_fetch_control.md
# branch_fetch_control

Fetch-side PC sequencer that consumes the 2-bit branch predictor's take/not-take output and produces the predictor's training inputs. It holds the fetch PC and redirects it on predicted-taken branches. It tracks a single outstanding predicted branch until the execute stage resolves it. On a misprediction it flushes the pipeline and restarts fetch on the correct path, and on every resolution it issues a one-cycle update pulse to the predictor.

## Interface
- ADDR_W, 32, PC/address width
- RESET_PC, 0, oPC value after reset
- INSTR_BYTES, 4, PC increment per sequential fetch
- CNT_W, 16, mispredict counter width
- iClk  in  1  clock, rising edge
- iRst_n  in  1  reset; one clock, reset is asynchronous and active-low
- iStall  in  1  hold PC (pipeline stall)
- iBranchDecoded  in  1  decode presents a conditional branch this cycle
- iBranchPC  in  ADDR_W  address of the decoded branch
- iBranchTarget  in  ADDR_W  taken target of the decoded branch
- iPredictTake  in  1  predictor direction (from the predictor's take output)
- iResolveValid  in  1  execute resolves the outstanding branch this cycle
- iResolveTaken  in  1  actual outcome, qualified by iResolveValid
- oPC  out  ADDR_W  current fetch address, registered
- oFlush  out  1  registered one-cycle pulse, kill wrong-path instructions
- oBranchCmd  out  1  registered one-cycle predictor update strobe
- oBranchTaken  out  1  outcome for the update, valid with oBranchCmd
- oBranchHold  out  1  combinational: decoded branch refused, decode must hold it
- oMispredictCount  out  CNT_W  saturating mispredict count

## Operation
- States: IDLE (no branch outstanding) and PENDING (one branch outstanding). PENDING saves: predicted direction, target, and fall-through (iBranchPC+INSTR_BYTES mod 2^ADDR_W).
- Reset values: state=IDLE, oPC=RESET_PC, oFlush=0, oBranchCmd=0, oBranchTaken=0, oMispredictCount=0.
- resolve = iResolveValid && state==PENDING. iResolveValid in IDLE is ignored: no pulse, no state change.
- mispredict = resolve && (iResolveTaken != saved prediction).
- accept = iBranchDecoded && !iStall && !mispredict && (state==IDLE || resolve).
- oBranchHold = iBranchDecoded && state==PENDING && !iResolveValid.
- A branch decoded in the same cycle as a mispredict is wrong-path. It is dropped silently, with no hold and no accept.
- Next-PC priority, highest first:
  - mispredict: PC <= iResolveTaken ? saved target : saved fall-through. This overrides iStall.
  - iStall: PC held.
  - accept && iPredictTake: PC <= iBranchTarget.
  - otherwise: PC <= PC+INSTR_BYTES, wrapping modulo 2^ADDR_W.
- Transitions:
  - IDLE→PENDING on accept.
  - PENDING→IDLE on resolve without accept.
  - PENDING→PENDING on resolve with accept; the new branch's record replaces the old one.
  - Mispredict always ends in IDLE.
- On resolve: oBranchCmd<=1 and oBranchTaken<=iResolveTaken for exactly the next cycle. Otherwise oBranchCmd<=0 and oBranchTaken<=0.
- On mispredict: oFlush<=1 for the next cycle, and oMispredictCount increments, saturating at 2^CNT_W-1.
- Async reset asserted mid-PENDING discards the record immediately. No update pulse or flush is emitted afterwards.

## Timing
- All outputs except oBranchHold are registered. Effects appear on the cycle after the triggering edge.
- Predicted-taken redirect: branch accepted at edge N, oPC=target from N+1. Zero bubbles inside this block.
- Mispredict recovery: resolve at edge N. oPC=correct address and oFlush=1 both during N+1, aligned. oFlush is 0 at N+2.
- Predictor update: oBranchCmd is high during N+1 only. The predictor's state changes at edge N+1, and its take output reflects the new state from N+2.
- iPredictTake is sampled only at the accepting edge.
- oBranchHold is valid within the same cycle. Upstream is responsible for converting it into iStall.

## Test plan
- Reset with RESET_PC=0, then 4 free cycles -> oPC sequence 0x0,0x4,0x8,0xC; oFlush=0 and oBranchCmd=0 throughout.
- Branch at 0x8, target 0x40, iPredictTake=1; resolve taken 3 cycles later -> oPC=0x40 the next cycle; at resolve+1, oBranchCmd=1, oBranchTaken=1, oFlush=0, count stays 0.
- Same setup but resolve not-taken -> at resolve+1, oPC=0xC, oFlush=1 for one cycle, oBranchCmd=1, oBranchTaken=0, oMispredictCount=1.
- Branch at 0x20, target 0x80, predict not-taken; resolve taken while iStall=1 -> oPC=0x80 and oFlush=1 next cycle (stall overridden); state IDLE.
- Second branch while PENDING with no resolve -> oBranchHold=1 in the same cycle, the PENDING record is unchanged; resolve correct alongside a new branch -> new branch accepted, still PENDING, update pulse for the old branch.
- RESET_PC=0xFFFFFFFC -> oPC wraps to 0x0 after one cycle; iRst_n low asynchronously mid-PENDING -> oPC=0xFFFFFFFC immediately, and no flush or update pulse after release.
